// File: rtl/writeback_retire.sv
// Multi-lane writeback/retire stage: registered register-file writes,
// retired-instruction counter and an in-order retire trace FIFO.
module writeback_retire #(
  parameter int LANES       = 2,
  parameter int ADDR_WIDTH  = 30,
  parameter int INSN_WIDTH  = 32,
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int TRACE_DEPTH = 8,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*ADDR_WIDTH-1:0] in_addr,
  input  logic [LANES*INSN_WIDTH-1:0] in_insn,
  input  logic [LANES*REG_AW-1:0]     in_rd,
  input  logic [LANES-1:0]            in_rd_we,
  input  logic [LANES*XLEN-1:0]       in_result,
  output logic                        in_ready,
  output logic [LANES-1:0]            rf_we,
  output logic [LANES*REG_AW-1:0]     rf_waddr,
  output logic [LANES*XLEN-1:0]       rf_wdata,
  output logic                        trace_valid,
  input  logic                        trace_ready,
  output logic [ADDR_WIDTH-1:0]       trace_addr,
  output logic [INSN_WIDTH-1:0]       trace_insn,
  output logic [CNT_WIDTH-1:0]        retire_count
);

  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int NW = $clog2(LANES + 1);
  localparam int EW = ADDR_WIDTH + INSN_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  logic [EW-1:0]    mem [TRACE_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    slot [LANES];
  logic [PW-1:0]    off;
  logic [LANES-1:0] we_raw, we_fin;
  logic [NW-1:0]    n_valid;
  logic             fire, pop;
  logic [EW-1:0]    head;

  assign in_ready    = rst & ((DEPTH_C - count) >= LANES_C);
  assign fire        = in_ready & (|in_valid);
  assign trace_valid = (count != '0);
  assign pop         = trace_valid & trace_ready;
  assign head        = mem[rd_ptr];
  assign trace_addr  = head[EW-1:INSN_WIDTH];
  assign trace_insn  = head[INSN_WIDTH-1:0];

  // Per-lane write enables with youngest-lane-wins collision filtering,
  // valid popcount, and FIFO slot for each valid lane in lane order.
  always_comb begin
    we_raw  = '0;
    we_fin  = '0;
    n_valid = '0;
    off     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      we_raw[i] = in_valid[i] & in_rd_we[i] & (in_rd[i*REG_AW +: REG_AW] != '0);
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      we_fin[i] = we_raw[i];
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (we_raw[j] && (in_rd[j*REG_AW +: REG_AW] == in_rd[i*REG_AW +: REG_AW]))
          we_fin[i] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr + off;
      if (in_valid[i]) begin
        off     = off + 1'b1;
        n_valid = n_valid + 1'b1;
      end
    end
  end

  // Register-file write port, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= fire ? we_fin : '0;
      if (fire) begin
        rf_waddr <= in_rd;
        rf_wdata <= in_result;
      end
    end
  end

  // Retired-instruction counter, wraps at its natural width.
  always_ff @(posedge clk) begin
    if (!rst)
      retire_count <= '0;
    else if (fire)
      retire_count <= retire_count + CNT_WIDTH'(n_valid);
  end

  // Trace FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire)
        wr_ptr <= wr_ptr + PW'(n_valid);
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (fire ? CW'(n_valid) : '0) - CW'(pop);
    end
  end

  // Trace FIFO storage; valid lanes land in consecutive slots in lane order.
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (in_valid[i])
          mem[slot[i]] <= {in_addr[i*ADDR_WIDTH +: ADDR_WIDTH], in_insn[i*INSN_WIDTH +: INSN_WIDTH]};
      end
    end
  end

endmodule
